// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch FSM encoding and instruction constants.
package fetch_stage_pkg;
    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;
    localparam logic [3:0]  HLT_OP = 4'hF;
    localparam logic [15:0] NOP    = 16'h0000;
endpackage

// File: rtl/fetch_out_buf.sv
// fetch_out_buf: one-entry instruction/PC+2 buffer feeding the IF/ID register.
module fetch_out_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc2_in,
    output logic        valid,
    output logic [15:0] instr,
    output logic [15:0] pc2
);
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d, pc2_q, pc2_d;
    always_comb begin
        valid_d = flush ? 1'b0 : (load | (valid_q & ~consume));
        instr_d = (load & ~flush) ? instr_in : instr_q;
        pc2_d   = (load & ~flush) ? pc2_in : pc2_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
            pc2_q   <= 16'h0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
        end
    end
    assign valid = valid_q;
    assign instr = instr_q;
    assign pc2   = pc2_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one imem request at a time, with redirect, stall and HLT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = HLT_OP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_data_valid,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] instruction,
    output logic [15:0] PC_plus_two,
    output logic        halted,
    output logic [15:0] fetch_wait_cnt
);
    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d, cnt_q, cnt_d;
    logic         discard_q, discard_d, halted_q, halted_d;
    logic         consume, buf_free, load;
    always_comb begin
        consume   = if_valid & ~stall;
        buf_free  = ~if_valid | consume;
        imem_req  = rst & (state_q == ST_REQ) & buf_free & ~branch_taken;
        imem_addr = pc_q;
        load      = (state_q == ST_WAIT) & imem_data_valid & ~discard_q & ~branch_taken;
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        halted_d  = halted_q;
        cnt_d     = (state_q == ST_WAIT && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        if (branch_taken) begin
            pc_d      = branch_target;
            halted_d  = 1'b0;
            // an in-flight request whose data is not here yet must be swallowed later
            discard_d = (state_q == ST_WAIT) & ~imem_data_valid;
            state_d   = discard_d ? ST_WAIT : ST_REQ;
        end else begin
            case (state_q)
                ST_REQ:    state_d = imem_req ? ST_WAIT : ST_REQ;
                ST_WAIT: begin
                    if (imem_data_valid) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                        if (load) begin
                            pc_d = pc_q + 16'd2;
                            if (imem_data[15:12] == HLT_OPCODE) begin
                                state_d  = ST_HALTED;
                                halted_d = 1'b1;
                            end
                        end
                    end
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_REQ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            cnt_q     <= 16'h0000;
            discard_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            halted_q  <= halted_d;
        end
    end
    fetch_out_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .consume  (consume),
        .flush    (branch_taken),
        .instr_in (imem_data),
        .pc2_in   (pc_q + 16'd2),
        .valid    (if_valid),
        .instr    (instruction),
        .pc2      (PC_plus_two)
    );
    assign halted         = halted_q;
    assign fetch_wait_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random stall/branch/latency against a transaction-level model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, imem_data_valid = 1'b0;
    logic [15:0] branch_target = '0, imem_data = '0;
    logic        imem_req, if_valid, halted;
    logic [15:0] imem_addr, instruction, PC_plus_two, fetch_wait_cnt;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_data_valid(imem_data_valid), .imem_data(imem_data), .if_valid(if_valid),
        .instruction(instruction), .PC_plus_two(PC_plus_two), .halted(halted),
        .fetch_wait_cnt(fetch_wait_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    // stimulus knobs
    bit          s_stall = 0, s_br = 0, stray = 0;
    logic [15:0] s_tgt = '0, hlt_addr = 16'hFFFF;
    int          s_lat = 1;
    // memory responder
    bit          pend = 0;
    int          plat = 0;
    logic [15:0] pdata = '0;
    logic [15:0] dq[$];
    bit          last_req;
    logic [15:0] last_addr;
    // reference model: one outstanding fetch, one buffered instruction
    bit          m_busy, m_drop, m_halt, m_bv;
    logic [15:0] m_pc, m_instr, m_pc2, m_cnt;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == hlt_addr) ? 16'hF000 : {1'b0, a[14:0] ^ 15'h5A5A};
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_busy = 0; m_drop = 0; m_halt = 0; m_bv = 0;
        m_instr = 16'h0000; m_pc2 = 16'h0000; m_cnt = 16'h0000;
    endtask

    task automatic model_step(input bit took_req);
        if (m_busy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (branch_taken) begin
            m_bv = 0; m_pc = branch_target; m_halt = 0;
            m_drop = m_busy && !imem_data_valid;
            m_busy = m_drop;
        end else begin
            if (m_bv && !stall) m_bv = 0;
            if (m_busy && imem_data_valid) begin
                m_busy = 0;
                if (m_drop) m_drop = 0;
                else begin
                    m_bv = 1; m_instr = imem_data; m_pc = m_pc + 16'd2; m_pc2 = m_pc;
                    m_halt = (imem_data[15:12] == 4'hF);
                end
            end else if (took_req) m_busy = 1;
        end
    endtask

    task automatic check_regs();
        chk("if_valid", 16'(if_valid), 16'(m_bv));
        if (m_bv) begin
            chk("instruction", instruction, m_instr);
            chk("PC_plus_two", PC_plus_two, m_pc2);
        end
        chk("halted", 16'(halted), 16'(m_halt));
        chk("fetch_wait_cnt", fetch_wait_cnt, m_cnt);
    endtask

    // one clock: drive inputs after negedge, check requests, advance, check registers
    task automatic cyc();
        bit exp_req;
        stall = s_stall; branch_taken = s_br; branch_target = s_tgt;
        imem_data_valid = stray | (pend && plat == 1);
        imem_data = stray ? 16'hF000 : pdata;
        #1;
        exp_req = rst && !m_busy && !m_halt && !(m_bv && stall) && !branch_taken;
        chk("imem_req", 16'(imem_req), 16'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        last_req = imem_req; last_addr = imem_addr;
        @(posedge clk);
        if (!rst) model_reset(); else model_step(exp_req);
        stray = 0;
        if (pend) begin
            if (plat == 1) pend = 0; else plat--;
        end
        if (last_req && rst) begin
            pend = 1;
            plat = (s_lat == 0) ? int'($urandom_range(1, 3)) : s_lat;
            pdata = (dq.size() > 0) ? dq.pop_front() : mem_word(last_addr);
        end
        if (!rst) pend = 0;
        @(negedge clk);
        check_regs();
    endtask

    task automatic wait_req(input string tag, input logic [15:0] a);
        int i = 0;
        do begin cyc(); i++; end while (!last_req && i < 8);
        chk({tag, "_seen"}, 16'(last_req), 16'd1);
        chk(tag, last_addr, a);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_pc2", PC_plus_two, 16'h0000);
        check_regs();
        rst = 1'b1;
        // back-to-back fetches, one-cycle memory
        dq.push_back(16'h1234); dq.push_back(16'h5678);
        cyc(); chk("t1_addr0", last_addr, 16'h0000);
        cyc(); chk("t1_instr0", instruction, 16'h1234); chk("t1_pc2_0", PC_plus_two, 16'h0002);
        cyc(); chk("t1_addr1", last_addr, 16'h0002);
        cyc(); chk("t1_pc2_1", PC_plus_two, 16'h0004); chk("t1_cnt", fetch_wait_cnt, 16'd2);
        // stall with full buffer
        s_stall = 1; n = 0;
        repeat (4) begin cyc(); n += int'(last_req); end
        chk("t2_noreq", 16'(n), 16'd0);
        chk("t2_instr", instruction, 16'h5678); chk("t2_pc2", PC_plus_two, 16'h0004);
        s_stall = 0; s_lat = 3;
        cyc(); chk("t2_release_req", 16'(last_req), 16'd1); chk("t2_addr", last_addr, 16'h0004);
        // redirect while waiting; late response is dropped
        s_br = 1; s_tgt = 16'h0100; cyc(); s_br = 0;
        cyc(); cyc();
        chk("t3_dropped", 16'(if_valid), 16'd0);
        s_lat = 1;
        cyc(); chk("t3_req", 16'(last_req), 16'd1); chk("t3_addr", last_addr, 16'h0100);
        // HLT at 0x0010
        hlt_addr = 16'h0010;
        s_br = 1; s_tgt = 16'h0010; cyc(); s_br = 0;
        wait_req("t4_addr", 16'h0010);
        for (int i = 0; i < 10 && !halted; i++) cyc();
        chk("t4_halted", 16'(halted), 16'd1);
        chk("t4_valid", 16'(if_valid), 16'd1);
        chk("t4_pc2", PC_plus_two, 16'h0012);
        chk("t4_instr", instruction, 16'hF000);
        n = 0;
        repeat (10) begin cyc(); n += int'(last_req); end
        chk("t4_noreq", 16'(n), 16'd0);
        hlt_addr = 16'hFFFF;
        s_br = 1; s_tgt = 16'h0020; cyc(); s_br = 0;
        chk("t4_unhalt", 16'(halted), 16'd0);
        wait_req("t4_redir", 16'h0020);
        // PC wrap
        s_br = 1; s_tgt = 16'hFFFE; cyc(); s_br = 0;
        wait_req("t5_addr", 16'hFFFE);
        cyc();
        chk("t5_valid", 16'(if_valid), 16'd1);
        chk("t5_pc2", PC_plus_two, 16'h0000);
        s_lat = 3;
        wait_req("t5_wrap", 16'h0000);
        cyc();
        // async reset in the middle of a wait
        #2 rst = 1'b0;
        #1;
        chk("t6_req", 16'(imem_req), 16'd0);
        chk("t6_valid", 16'(if_valid), 16'd0);
        chk("t6_instr", instruction, 16'h0000);
        chk("t6_pc2", PC_plus_two, 16'h0000);
        chk("t6_halted", 16'(halted), 16'd0);
        chk("t6_cnt", fetch_wait_cnt, 16'd0);
        model_reset(); pend = 0;
        @(negedge clk);
        repeat (2) cyc();
        rst = 1'b1; stray = 1;
        cyc(); chk("t6_first", last_addr, 16'h0000);
        repeat (5) cyc();
        chk("t6_stray_ignored", 16'(halted), 16'd0);
        // random traffic
        s_lat = 0; hlt_addr = 16'h0040;
        repeat (1500) begin
            s_stall = ($urandom_range(0, 9) < 3);
            s_br = ($urandom_range(0, 19) == 0);
            s_tgt = 16'($urandom_range(0, 63)) << 1;
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
